// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the H:M:S timer sequencer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_H  = 8'h23;

  // Both digits decimal and the packed value within the field limit.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic prog_valid(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
    return bcd_valid(h, BCD_MAX_H) && bcd_valid(m, BCD_MAX_MS) &&
           bcd_valid(s, BCD_MAX_MS) && ({h, m, s} != 24'h0);
  endfunction

endpackage

// File: rtl/bcd_hms_counter.sv
// Packed-BCD H:M:S counter with clear, load and single-second step (up or down).
module bcd_hms_counter
  import timer_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] load_h_i,
  input  logic [7:0] load_m_i,
  input  logic [7:0] load_s_i,
  input  logic       step_i,
  output logic [7:0] h_o,
  output logic [7:0] m_o,
  output logic [7:0] s_o
);

  logic [7:0] h_q, m_q, s_q;
  logic [7:0] h_d, m_d, s_d;
  logic [8:0] h_nx, m_nx, s_nx;

  // Result is {carry/borrow, next value}.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)            return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)          return {1'b1, max};
    else if (v[3:0] == 4'd0) return {1'b0, v[7:4] - 4'd1, 4'd9};
    else                     return {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    s_nx = DOWN ? bcd_dec(s_q, BCD_MAX_MS) : bcd_inc(s_q, BCD_MAX_MS);
    m_nx = DOWN ? bcd_dec(m_q, BCD_MAX_MS) : bcd_inc(m_q, BCD_MAX_MS);
    h_nx = DOWN ? bcd_dec(h_q, BCD_MAX_H)  : bcd_inc(h_q, BCD_MAX_H);
  end

  always_comb begin
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    if (clr_i) begin
      h_d = 8'h00;
      m_d = 8'h00;
      s_d = 8'h00;
    end else if (load_i) begin
      h_d = load_h_i;
      m_d = load_m_i;
      s_d = load_s_i;
    end else if (step_i) begin
      s_d = s_nx[7:0];
      if (s_nx[8]) begin
        m_d = m_nx[7:0];
        if (m_nx[8]) h_d = h_nx[7:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q <= 8'h00;
      m_q <= 8'h00;
      s_q <= 8'h00;
    end else begin
      h_q <= h_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign h_o = h_q;
  assign m_o = m_q;
  assign s_o = s_q;

endmodule

// File: rtl/timer_sequencer.sv
// H:M:S timer with run/pause/done FSM, one-second prescaler and timed alarm.
// Define COUNTDOWN_EN to count down from the program to 00:00:00 instead of up.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] prog_h,
  input  logic [7:0] prog_m,
  input  logic [7:0] prog_s,
  output logic [7:0] count_h,
  output logic [7:0] count_m,
  output logic [7:0] count_s,
  output logic [1:0] state,
  output logic       fin,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [7:0]    prog_h_q, prog_m_q, prog_s_q;
  logic [7:0]    prog_h_d, prog_m_d, prog_s_d;
  logic          fin_q, fin_d, alarm_q, alarm_d;

  logic          tick, accept, at_term;
  logic          cnt_clr, cnt_load, cnt_step;
  logic [7:0]    load_h, load_m, load_s;
  logic [23:0]   term;

`ifdef COUNTDOWN_EN
  localparam bit COUNT_DOWN = 1'b1;
  assign load_h = prog_h;
  assign load_m = prog_m;
  assign load_s = prog_s;
  assign term   = 24'h000000;
`else
  localparam bit COUNT_DOWN = 1'b0;
  assign load_h = 8'h00;
  assign load_m = 8'h00;
  assign load_s = 8'h00;
  assign term   = {prog_h_q, prog_m_q, prog_s_q};
`endif

  bcd_hms_counter #(.DOWN(COUNT_DOWN)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .load_i   (cnt_load),
    .load_h_i (load_h),
    .load_m_i (load_m),
    .load_s_i (load_s),
    .step_i   (cnt_step),
    .h_o      (count_h),
    .m_o      (count_m),
    .s_o      (count_s)
  );

  assign tick    = ((state_q == ST_RUN) || (state_q == ST_DONE)) && (presc_q == PRESC_LAST);
  assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                   prog_valid(prog_h, prog_m, prog_s);
  assign at_term = ({count_h, count_m, count_s} == term);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    alarm_cnt_d = alarm_cnt_q;
    prog_h_d    = prog_h_q;
    prog_m_d    = prog_m_q;
    prog_s_d    = prog_s_q;
    fin_d       = fin_q;
    alarm_d     = alarm_q;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;

    if ((state_q == ST_RUN) || (state_q == ST_DONE))
      presc_d = tick ? '0 : presc_q + PW'(1);

    if (clear) begin
      state_d     = ST_IDLE;
      presc_d     = '0;
      alarm_cnt_d = '0;
      fin_d       = 1'b0;
      alarm_d     = 1'b0;
      cnt_clr     = 1'b1;
    end else if (accept) begin
      state_d     = ST_RUN;
      presc_d     = '0;
      alarm_cnt_d = '0;
      prog_h_d    = prog_h;
      prog_m_d    = prog_m;
      prog_s_d    = prog_s;
      fin_d       = 1'b0;
      alarm_d     = 1'b0;
      cnt_load    = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // Restart the prescaler on entry so DONE sees whole alarm seconds.
          if (at_term) begin
            state_d     = ST_DONE;
            presc_d     = '0;
            alarm_cnt_d = '0;
            fin_d       = 1'b1;
            alarm_d     = 1'b1;
          end else begin
            cnt_step = tick;
            if (pause) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (tick) begin
            if (alarm_cnt_q == ALARM_LAST) begin
              state_d     = ST_IDLE;
              alarm_cnt_d = '0;
              fin_d       = 1'b0;
              alarm_d     = 1'b0;
            end else begin
              alarm_cnt_d = alarm_cnt_q + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      prog_h_q    <= 8'h00;
      prog_m_q    <= 8'h00;
      prog_s_q    <= 8'h00;
      fin_q       <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      alarm_cnt_q <= alarm_cnt_d;
      prog_h_q    <= prog_h_d;
      prog_m_q    <= prog_m_d;
      prog_s_q    <= prog_s_d;
      fin_q       <= fin_d;
      alarm_q     <= alarm_d;
    end
  end

  assign state = state_q;
  assign fin   = fin_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed-vector bench for timer_sequencer with TICK_DIV=4, ALARM_SECS=2.
module tb_timer_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int ALARM_SECS = 2;
`ifdef COUNTDOWN_EN
  localparam bit DOWN_BUILD = 1'b1;
`else
  localparam bit DOWN_BUILD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, start, pause, clear;
  logic [7:0] prog_h, prog_m, prog_s;
  logic [7:0] count_h, count_m, count_s;
  logic [1:0] state;
  logic       fin, alarm;
  logic [23:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;
  assign cnt = {count_h, count_m, count_s};

  timer_sequencer #(.TICK_DIV(TICK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .prog_h  (prog_h),
    .prog_m  (prog_m),
    .prog_s  (prog_s),
    .count_h (count_h),
    .count_m (count_m),
    .count_s (count_s),
    .state   (state),
    .fin     (fin),
    .alarm   (alarm)
  );

  typedef struct {
    logic [7:0] h, m, s;
    logic       st, pa, cl;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic launch(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    prog_h = h;
    prog_m = m;
    prog_s = s;
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] hms(input int secs);
    int t;
    t = ((secs % 86400) + 86400) % 86400;
    return {bcd2(t / 3600), bcd2((t / 60) % 60), bcd2(t % 60)};
  endfunction

  // Expected display after 'el' seconds of a 'prog'-second program.
  function automatic logic [23:0] exp_cnt(input int prog, input int el);
    return DOWN_BUILD ? hms(prog - el) : hms(el);
  endfunction

  initial begin
    int rise, fall;
    logic [23:0] e;

    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    prog_h = 8'h00; prog_m = 8'h00; prog_s = 8'h00;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{8'h00, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[2] = '{8'h00, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{8'h24, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{8'h00, 8'h60, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[6] = '{8'h23, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[7] = '{8'h00, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[8] = '{8'h00, 8'h00, 8'h05, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[9] = '{8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b0, 2'd1};

    // Reset state
    cyc(2);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", 32'(cnt), 32'd0);
    chk("reset_fin", 32'(fin), 32'd0);
    chk("reset_alarm", 32'(alarm), 32'd0);
    reset = 1'b0;
    cyc(1);

    // Start acceptance table
    for (int i = 0; i < 10; i++) begin
      do_clear();
      prog_h = tbl[i].h; prog_m = tbl[i].m; prog_s = tbl[i].s;
      start = tbl[i].st; pause = tbl[i].pa; clear = tbl[i].cl;
      cyc(1);
      start = 1'b0; pause = 1'b0; clear = 1'b0;
      e = (tbl[i].exp_state == 2'd1 && DOWN_BUILD) ? {tbl[i].h, tbl[i].m, tbl[i].s} : 24'h0;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      chk($sformatf("vec%0d_count", i), 32'(cnt), 32'(e));
    end

    // 3-second run, program change after latch, fin/alarm timing
    do_clear();
    launch(8'h00, 8'h00, 8'h03);
    prog_s = 8'h09;
    rise = -1; fall = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (k == 4 || k == 8 || k == 12)
        chk($sformatf("run3_count_k%0d", k), 32'(cnt), 32'(exp_cnt(3, k / 4)));
      if (fin && rise < 0) begin
        rise = k;
        chk("run3_done_state", 32'(state), 32'd3);
        chk("run3_alarm_on", 32'(alarm), 32'd1);
      end
      if (k == 18) chk("run3_done_hold", 32'(cnt), 32'(exp_cnt(3, 3)));
      if (rise >= 0 && !alarm && fall < 0) fall = k;
    end
    chk("run3_fin_latency", rise, 13);
    chk("run3_alarm_window", fall - rise, 8);
    chk("run3_back_idle", 32'(state), 32'd0);
    chk("run3_fin_low", 32'(fin), 32'd0);

    // Minute rollover / first borrow
    do_clear();
    launch(8'h00, 8'h01, 8'h00);
    cyc(4);
    chk("min_first_tick", 32'(cnt), 32'(exp_cnt(60, 1)));
    cyc(232);
    chk("min_tick59", 32'(cnt), 32'(exp_cnt(60, 59)));
    cyc(4);
    chk("min_tick60", 32'(cnt), 32'(exp_cnt(60, 60)));
    chk("min_fin_not_yet", 32'(fin), 32'd0);
    cyc(1);
    chk("min_fin", 32'(fin), 32'd1);

    // Pause hold for 20 clocks
    do_clear();
    launch(8'h00, 8'h00, 8'h03);
    cyc(4);
    chk("pause_pre_count", 32'(cnt), 32'(exp_cnt(3, 1)));
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("pause_enter", 32'(state), 32'd2);
    cyc(20);
    chk("pause_still", 32'(state), 32'd2);
    chk("pause_frozen", 32'(cnt), 32'(exp_cnt(3, 1)));
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("pause_resume", 32'(state), 32'd1);
    rise = -1;
    for (int k = 27; k <= 45; k++) begin
      cyc(1);
      if (fin && rise < 0) rise = k;
    end
    chk("pause_fin_at", rise, 34);

    // Tick coinciding with pause is applied
    do_clear();
    launch(8'h00, 8'h00, 8'h03);
    cyc(3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("tickpause_state", 32'(state), 32'd2);
    chk("tickpause_count", 32'(cnt), 32'(exp_cnt(3, 1)));

    // start+pause+clear together in RUN
    do_clear();
    launch(8'h00, 8'h00, 8'h03);
    cyc(5);
    start = 1'b1; pause = 1'b1; clear = 1'b1;
    cyc(1);
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    chk("allreq_state", 32'(state), 32'd0);
    chk("allreq_count", 32'(cnt), 32'd0);
    chk("allreq_fin", 32'(fin), 32'd0);

    // Restart from DONE, then clear from DONE
    launch(8'h00, 8'h00, 8'h01);
    cyc(5);
    chk("d1_fin", 32'(fin), 32'd1);
    launch(8'h00, 8'h00, 8'h02);
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_alarm", 32'(alarm), 32'd0);
    chk("restart_count", 32'(cnt), 32'(exp_cnt(2, 0)));
    cyc(9);
    chk("d2_state", 32'(state), 32'd3);
    do_clear();
    chk("clr_done_state", 32'(state), 32'd0);
    chk("clr_done_alarm", 32'(alarm), 32'd0);
    chk("clr_done_count", 32'(cnt), 32'd0);

    // Reset overrides start in RUN and DONE
    launch(8'h00, 8'h00, 8'h03);
    cyc(6);
    reset = 1'b1; start = 1'b1;
    cyc(1);
    reset = 1'b0; start = 1'b0;
    chk("rst_run_state", 32'(state), 32'd0);
    chk("rst_run_count", 32'(cnt), 32'd0);
    launch(8'h00, 8'h00, 8'h01);
    cyc(5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rst_done_state", 32'(state), 32'd0);
    chk("rst_done_fin", 32'(fin), 32'd0);
    chk("rst_done_alarm", 32'(alarm), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
